// File: rtl/disp_arb_pkg.sv
// ----------------------------------------------------------------------------
// disp_arb_pkg
// Shared definitions for the display share arbiter.
//   disp_state_t     : arbiter FSM state (IDLE, SHOW)
//   DEF_N_REQ        : default number of requesters
//   DEF_HOLD_CYCLES  : default minimum display time per grant (1 s at 100 MHz)
//   DEF_CNT_W        : default hold counter width (2**DEF_CNT_W > DEF_HOLD_CYCLES)
//   DIGIT_IDLE       : nibble value shown after reset and in ID mode while idle
// ----------------------------------------------------------------------------
package disp_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } disp_state_t;

    localparam int DEF_N_REQ       = 4;
    localparam int DEF_HOLD_CYCLES = 100_000_000;
    localparam int DEF_CNT_W       = 27;

    localparam logic [3:0] DIGIT_IDLE = 4'h0;

endpackage

// File: rtl/display_share_arbiter_rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker: returns the lowest requester index at or
// after i_pointer, wrapping N_REQ-1 -> 0.
// Ports:
//   i_req     in  N_REQ   request vector (already masked by the caller)
//   i_pointer in  IDX_W   index with highest priority this cycle
//   o_valid   out 1       at least one request present
//   o_winner  out IDX_W   winning index (0 when o_valid is 0)
// ----------------------------------------------------------------------------
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_pointer,
    output logic             o_valid,
    output logic [IDX_W-1:0] o_winner
);

    localparam logic [IDX_W:0] N_L = (IDX_W+1)'(N_REQ);

    logic [IDX_W:0] w_pos;

    // Scan from the farthest offset down to offset 0 so the last hit, which
    // is the closest index at/after the pointer, is the one that sticks.
    always_comb begin
        o_valid  = 1'b0;
        o_winner = '0;
        w_pos    = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_pos = {1'b0, i_pointer} + (IDX_W+1)'(k);
            if (w_pos >= N_L) begin
                w_pos = w_pos - N_L;
            end
            if (i_req[w_pos[IDX_W-1:0]]) begin
                o_valid  = 1'b1;
                o_winner = w_pos[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/display_share_arbiter.sv
// ----------------------------------------------------------------------------
// display_share_arbiter
// Time-shares one 4-digit seven-segment display between N_REQ requesters.
// Round-robin grant, each winner keeps the display for at least HOLD_CYCLES.
// Build option: DISP_SHOW_ID_EN -- d4 shows the owner index while busy
// (DIGIT_IDLE when idle) and d3..d1 show data[11:0]. Undefined: d4..d1 show
// all 16 data bits.
// Ports:
//   clk          in   1         system clock
//   rst          in   1         asynchronous, active-high reset
//   req          in   N_REQ     level requests
//   data         in   16*N_REQ  requester i value at data[16*i +: 16]
//   gnt          out  N_REQ     one-hot owner, zero when idle
//   busy         out  1         display owned by someone
//   d4,d3,d2,d1  out  4 each    nibbles to the display driver
//   o_state      out  1         FSM state, for observation
// Handshake: req is a level held by the requester; gnt is a one-hot level
// that stays up for at least HOLD_CYCLES cycles and is never pre-empted.
// ----------------------------------------------------------------------------
module display_share_arbiter
    import disp_arb_pkg::*;
#(
    parameter int N_REQ       = DEF_N_REQ,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [16*N_REQ-1:0]  data,
    output logic [N_REQ-1:0]     gnt,
    output logic                 busy,
    output logic [3:0]           d4,
    output logic [3:0]           d3,
    output logic [3:0]           d2,
    output logic [3:0]           d1,
    output disp_state_t          o_state
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_REQ - 1);

    disp_state_t      r_state, w_state;
    logic [N_REQ-1:0] r_gnt, w_gnt;
    logic [IDX_W-1:0] r_owner, w_owner;
    logic [IDX_W-1:0] r_ptr, w_ptr;
    logic [CNT_W-1:0] r_cnt, w_cnt;
    logic [15:0]      r_digits, w_digits;

    logic             w_pick_valid;
    logic [IDX_W-1:0] w_pick_idx;
    logic [IDX_W-1:0] w_pick_next;
    logic [N_REQ-1:0] w_pick_onehot;
    logic [15:0]      w_owner_data;

    // The current owner is masked out, so at hold expiry a different
    // requester always wins if one is waiting. In IDLE r_gnt is zero.
    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .i_req     (req & ~r_gnt),
        .i_pointer (r_ptr),
        .o_valid   (w_pick_valid),
        .o_winner  (w_pick_idx)
    );

    assign w_pick_next  = (w_pick_idx == LAST_IDX) ? '0 : w_pick_idx + 1'b1;
    assign w_owner_data = data[{r_owner, 4'b0000} +: 16];

    always_comb begin
        w_pick_onehot             = '0;
        w_pick_onehot[w_pick_idx] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_gnt    <= '0;
            r_owner  <= '0;
            r_ptr    <= '0;
            r_cnt    <= '0;
            r_digits <= {4{DIGIT_IDLE}};
        end else begin
            r_state  <= w_state;
            r_gnt    <= w_gnt;
            r_owner  <= w_owner;
            r_ptr    <= w_ptr;
            r_cnt    <= w_cnt;
            r_digits <= w_digits;
        end
    end

    always_comb begin
        w_state  = r_state;
        w_gnt    = r_gnt;
        w_owner  = r_owner;
        w_ptr    = r_ptr;
        w_cnt    = r_cnt;
        w_digits = r_digits;
        case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_state = SHOW;
                    w_gnt   = w_pick_onehot;
                    w_owner = w_pick_idx;
                    w_ptr   = w_pick_next;
                    w_cnt   = HOLD_LOAD;
                end
            end
            SHOW: begin
                // Digits follow the owner only while it still requests;
                // otherwise they freeze at the last sampled value.
                if (req[r_owner]) begin
                    w_digits = w_owner_data;
                end
                if (r_cnt != '0) begin
                    w_cnt = r_cnt - 1'b1;
                end else if (w_pick_valid) begin
                    w_gnt   = w_pick_onehot;
                    w_owner = w_pick_idx;
                    w_ptr   = w_pick_next;
                    w_cnt   = HOLD_LOAD;
                end else if (req[r_owner]) begin
                    w_cnt = HOLD_LOAD;
                end else begin
                    w_state = IDLE;
                    w_gnt   = '0;
                end
            end
            default: begin
                w_state = IDLE;
                w_gnt   = '0;
            end
        endcase
    end

    assign gnt     = r_gnt;
    assign busy    = (r_state == SHOW);
    assign o_state = r_state;
    assign d3      = r_digits[11:8];
    assign d2      = r_digits[7:4];
    assign d1      = r_digits[3:0];

`ifdef DISP_SHOW_ID_EN
    assign d4 = busy ? {{(4-IDX_W){1'b0}}, r_owner} : DIGIT_IDLE;
`else
    assign d4 = r_digits[15:12];
`endif

endmodule

// File: tb/tb_display_share_arbiter.sv
// ----------------------------------------------------------------------------
// tb_display_share_arbiter
// Directed bench for display_share_arbiter with HOLD_CYCLES = 8, N_REQ = 4.
// Inputs change just after a falling edge; outputs are checked one falling
// edge later, i.e. half a cycle after the rising edge that produced them.
// ----------------------------------------------------------------------------
module tb_display_share_arbiter;
    import disp_arb_pkg::*;

    localparam int N   = 4;
    localparam int HLD = 8;

    logic          clk;
    logic          rst;
    logic [N-1:0]  req;
    logic [16*N-1:0] data;
    logic [N-1:0]  gnt;
    logic          busy;
    logic [3:0]    d4, d3, d2, d1;
    disp_state_t   st;

    int n_checks = 0;
    int n_errors = 0;

    display_share_arbiter #(
        .N_REQ       (N),
        .HOLD_CYCLES (HLD),
        .CNT_W       (27)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .data    (data),
        .gnt     (gnt),
        .busy    (busy),
        .d4      (d4),
        .d3      (d3),
        .d2      (d2),
        .d1      (d1),
        .o_state (st)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // exp_id is the owner nibble expected on d4 in the owner-ID build
    // (owner index while busy, 0 while idle).
    task automatic chk_digits(input string tag, input logic [15:0] exp_data, input logic [3:0] exp_id);
        logic [15:0] exp;
`ifdef DISP_SHOW_ID_EN
        exp = {exp_id, exp_data[11:0]};
`else
        exp = exp_data;
        if (exp_id == 4'hF) exp = 16'h0;
`endif
        chk(tag, {16'h0, d4, d3, d2, d1}, {16'h0, exp});
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 3 * HLD) begin
            tick();
            n++;
        end
        chk(tag, {31'h0, busy}, 32'h0);
    endtask

    initial begin : stim
        logic [3:0] own_tbl [4];
        logic [15:0] prev_d, cur_d, exp_d;
        int o;

        own_tbl[0] = 4'd0; own_tbl[1] = 4'd1; own_tbl[2] = 4'd3; own_tbl[3] = 4'd0;

        rst  = 1'b1;
        req  = '0;
        data = '0;
        tick();
        tick();

        // Reset state
        chk("rst_gnt",   {28'h0, gnt}, 32'h0);
        chk("rst_busy",  {31'h0, busy}, 32'h0);
        chk("rst_state", {31'h0, st}, {31'h0, IDLE});
        chk_digits("rst_digits", 16'h0000, 4'h0);
        rst = 1'b0;
        tick();
        chk("idle_noreq_gnt", {28'h0, gnt}, 32'h0);

        // Single requester 1 with BEEF
        data[31:16] = 16'hBEEF;
        req = 4'b0010;
        tick();
        chk("r1_gnt", {28'h0, gnt}, 32'h2);
        chk("r1_busy", {31'h0, busy}, 32'h1);
        chk_digits("r1_digits_lat", 16'h0000, 4'h1);
        tick();
        chk_digits("r1_digits", 16'hBEEF, 4'h1);
        repeat (20) tick();
        chk("r1_gnt_held", {28'h0, gnt}, 32'h2);
        data[31:16] = 16'h5A6B;
        tick();
        chk_digits("r1_digits_live", 16'h5A6B, 4'h1);
        req = '0;
        wait_idle("r1_idle");
        chk("r1_idle_gnt", {28'h0, gnt}, 32'h0);
        chk_digits("r1_idle_digits", 16'h5A6B, 4'h0);

        // Reset in the middle of a hold with gnt = 0100
        data[47:32] = 16'hA5C3;
        req = 4'b0100;
        tick();
        chk("r2_gnt", {28'h0, gnt}, 32'h4);
        tick();
        tick();
        chk_digits("r2_digits", 16'hA5C3, 4'h2);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_gnt",   {28'h0, gnt}, 32'h0);
        chk("async_rst_busy",  {31'h0, busy}, 32'h0);
        chk("async_rst_state", {31'h0, st}, {31'h0, IDLE});
        chk_digits("async_rst_digits", 16'h0000, 4'h0);
        tick();

        // Round robin over req = 1011 from reset: 0,1,3,0 at 8 cycles each
        rst = 1'b0;
        data[15:0]  = 16'h1010;
        data[31:16] = 16'h2121;
        data[47:32] = 16'h3232;
        data[63:48] = 16'h4343;
        req = 4'b1011;
        prev_d = 16'h0000;
        for (int i = 0; i < 4 * HLD; i++) begin
            tick();
            o = int'(own_tbl[i / HLD]);
            cur_d = data[16*o +: 16];
            exp_d = (i % HLD == 0) ? prev_d : cur_d;
            chk($sformatf("rr_gnt_%0d", i), {28'h0, gnt}, {28'h0, 4'b0001 << o});
            chk($sformatf("rr_busy_%0d", i), {31'h0, busy}, 32'h1);
            chk_digits($sformatf("rr_digits_%0d", i), exp_d, own_tbl[i / HLD]);
            prev_d = cur_d;
        end
        req = '0;
        wait_idle("rr_idle");

        // Owner drops request two cycles into hold: digits freeze, gnt held
        data[15:0] = 16'h1111;
        req = 4'b0001;
        for (int i = 0; i <= HLD; i++) begin
            tick();
            if (i < HLD) begin
                chk($sformatf("drop_gnt_%0d", i), {28'h0, gnt}, 32'h1);
                chk($sformatf("drop_busy_%0d", i), {31'h0, busy}, 32'h1);
            end else begin
                chk("drop_gnt_end",   {28'h0, gnt}, 32'h0);
                chk("drop_busy_end",  {31'h0, busy}, 32'h0);
                chk("drop_state_end", {31'h0, st}, {31'h0, IDLE});
            end
            if (i >= 1) chk_digits($sformatf("drop_digits_%0d", i), 16'h1111, 4'h0);
            if (i == 1) begin
                req = '0;
                data[15:0] = 16'h2222;
            end
        end

        // Late request 2 while 0 holds: no pre-emption
        data[15:0]  = 16'hCAFE;
        data[47:32] = 16'h7777;
        req = 4'b0001;
        for (int i = 0; i <= HLD + 1; i++) begin
            tick();
            chk($sformatf("nopre_gnt_%0d", i), {28'h0, gnt}, (i < HLD) ? 32'h1 : 32'h4);
            chk($sformatf("nopre_busy_%0d", i), {31'h0, busy}, 32'h1);
            if (i >= 1) chk_digits($sformatf("nopre_digits_%0d", i),
                                   (i <= HLD) ? 16'hCAFE : 16'h7777,
                                   (i < HLD) ? 4'h0 : 4'h2);
            if (i == 2) req = 4'b0101;
        end
        req = '0;
        wait_idle("nopre_idle");

        // Owner 3 with 1234 (owner ID shown on d4 in the ID build)
        data[63:48] = 16'h1234;
        req = 4'b1000;
        tick();
        chk("id_gnt", {28'h0, gnt}, 32'h8);
        tick();
        chk_digits("id_digits", 16'h1234, 4'h3);
        req = '0;
        wait_idle("id_idle");
        chk_digits("id_idle_digits", 16'h1234, 4'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
